// File: rtl/stream_sum_ctrl.sv
// stream_sum_ctrl: reduces a valid/ready stream to one total per stream through a shared external 3-input adder.
// Optional SUM_CTRL_COUNT_EN builds a saturating per-stream word counter on sum_count (else tied to 0). Rev 1.0
`default_nettype none

module stream_sum_ctrl #(
  parameter int W             = 32,
  parameter int ACC_W         = 64,
  parameter int ADDER_LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [ACC_W-1:0]   sum_data,
  output logic               sum_overflow,
  output logic [31:0]        sum_count,
  output logic [ACC_W-1:0]   add_a,
  output logic [ACC_W-1:0]   add_b,
  output logic [ACC_W-1:0]   add_c,
  input  logic [ACC_W+1:0]   add_p
);

  typedef enum logic [2:0] {
    COLLECT0 = 3'd0,
    COLLECT1 = 3'd1,
    ISSUE    = 3'd2,
    WAIT     = 3'd3,
    DONE     = 3'd4
  } state_t;

  // WAIT lasts ADDER_LATENCY cycles; the counter reaching zero marks the capture edge.
  localparam logic [2:0] WAIT_INIT = 3'(ADDER_LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     x0;
  logic [W-1:0]     x1;
  logic             last_flag;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic [2:0]       wait_cnt;
  logic             in_hs;
  logic             sum_hs;

  assign in_hs        = in_valid && in_ready;
  assign sum_hs       = sum_valid && sum_ready;
  assign sum_data     = acc;
  assign sum_overflow = overflow;

  always_ff @(posedge clock) begin
    if (reset) state <= COLLECT0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    sum_valid  = 1'b0;
    case (state)
      COLLECT0: begin
        in_ready = !reset;
        if (in_hs) state_next = in_last ? ISSUE : COLLECT1;
      end
      COLLECT1: begin
        in_ready = !reset;
        if (in_hs) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (wait_cnt == 3'd0) state_next = last_flag ? DONE : COLLECT0;
      end
      DONE: begin
        sum_valid = 1'b1;
        if (sum_ready) state_next = COLLECT0;
      end
      default: state_next = COLLECT0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0        <= '0;
      x1        <= '0;
      last_flag <= 1'b0;
      acc       <= '0;
      overflow  <= 1'b0;
      wait_cnt  <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_c     <= '0;
    end else begin
      case (state)
        COLLECT0: if (in_hs) begin
          x0        <= in_data;
          x1        <= '0;
          last_flag <= in_last;
        end
        COLLECT1: if (in_hs) begin
          x1        <= in_data;
          last_flag <= in_last;
        end
        ISSUE: begin
          add_a    <= ACC_W'(x0);
          add_b    <= ACC_W'(x1);
          add_c    <= acc;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            acc      <= add_p[ACC_W-1:0];
            overflow <= overflow | (|add_p[ACC_W+1:ACC_W]);
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: if (sum_ready) begin
          acc      <= '0;
          overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SUM_CTRL_COUNT_EN
  logic [31:0] word_cnt;

  always_ff @(posedge clock) begin
    if (reset)                          word_cnt <= '0;
    else if (sum_hs)                    word_cnt <= '0;
    else if (in_hs && word_cnt != '1)   word_cnt <= word_cnt + 32'd1;
  end

  assign sum_count = word_cnt;
`else
  assign sum_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_sum_ctrl.sv
// tb_stream_sum_ctrl: scoreboard bench for stream_sum_ctrl with a pipelined external adder model.
`default_nettype none

module tb_stream_sum_ctrl;

  localparam int    W     = 8;
  localparam int    ACC_W = 12;
  localparam int    LAT   = 2;
  localparam longint MOD  = longint'(1) << ACC_W;
`ifdef SUM_CTRL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             sum_ready = 1'b1;
  logic             in_ready;
  logic             sum_valid;
  logic             sum_overflow;
  logic [ACC_W-1:0] sum_data;
  logic [31:0]      sum_count;
  logic [ACC_W-1:0] add_a, add_b, add_c;
  logic [ACC_W+1:0] add_p;
  logic [ACC_W+1:0] add_stage;

  always #5 clock = ~clock;

  stream_sum_ctrl #(.W(W), .ACC_W(ACC_W), .ADDER_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_overflow(sum_overflow), .sum_count(sum_count),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_p(add_p)
  );

  // Two-edge adder: one pipeline register after the operand registers.
  always @(posedge clock) add_stage <= {2'b00, add_a} + {2'b00, add_b} + {2'b00, add_c};
  assign add_p = add_stage;

  typedef struct { longint sum; longint ovf; longint cnt; } exp_t;
  typedef struct { longint a; longint b; longint c; } ops_t;
  exp_t exp_q[$];
  ops_t ops_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  longint m_acc = 0;
  longint m_ovf = 0;
  longint m_cnt = 0;
  longint m_x0  = 0;
  bit     m_half = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_fail++;
    $display("FAIL %s: bound expired", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "aborted");
  endtask

  // Reference: each pair of words (or a lone last word) is added to the running total.
  task automatic close_group(input longint a, input longint b);
    longint t;
    ops_q.push_back('{a, b, m_acc});
    t = a + b + m_acc;
    if (t >= MOD) m_ovf = 1;
    m_acc = t % MOD;
  endtask

  task automatic model_word(input longint d, input bit last);
    m_cnt++;
    if (!m_half) begin
      if (last) close_group(d, 0);
      else begin m_x0 = d; m_half = 1'b1; end
    end else begin
      m_half = 1'b0;
      close_group(m_x0, d);
    end
    if (last) begin
      exp_q.push_back('{m_acc, m_ovf, CNT_EN ? m_cnt : 0});
      m_acc = 0; m_ovf = 0; m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_half = 1'b0;
    exp_q.delete();
    ops_q.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input bit last, input int gap);
    int t = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
    model_word(d, last);
    in_valid = 1'b1; in_data = d; in_last = last;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      t++;
      if (t > 200) abort("in_ready_timeout");
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 3000) begin @(posedge clock); t++; end
    #1;
    chk("drain_pending_totals", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_sum_valid"}, sum_valid, 0);
    chk({tag, "_sum_data"}, sum_data, 0);
    chk({tag, "_sum_overflow"}, sum_overflow, 0);
    chk({tag, "_sum_count"}, sum_count, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
    chk({tag, "_add_c"}, add_c, 0);
  endtask

  initial begin
    forever begin
      @(posedge clock); #2;
      if (rand_ready) sum_ready = ($urandom % 3) != 0;
    end
  end

  // Totals monitor: pops on every sum handshake, checks hold under back-pressure.
  initial begin
    bit pv = 1'b0, pacc = 1'b0;
    logic [ACC_W-1:0] pd;
    logic po;
    logic [31:0] pc;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin pv = 1'b0; pacc = 1'b0; continue; end
      if (pacc) chk("sum_valid_drop", sum_valid, 0);
      else if (pv) begin
        chk("hold_valid", sum_valid, 1);
        chk("hold_data", sum_data, pd);
        chk("hold_overflow", sum_overflow, po);
        chk("hold_count", sum_count, pc);
      end
      if (sum_valid) chk("in_ready_in_done", in_ready, 0);
      if (sum_valid && sum_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_total: got %0d expected none", sum_data);
        end else begin
          e = exp_q.pop_front();
          chk("sum_data", sum_data, e.sum);
          chk("sum_overflow", sum_overflow, e.ovf);
          chk("sum_count", sum_count, e.cnt);
        end
      end
      pv = sum_valid; pacc = sum_valid && sum_ready;
      pd = sum_data; po = sum_overflow; pc = sum_count;
    end
  end

  // Operand monitor: operands appear two cycles after the handshake that completes a group.
  initial begin
    bit half = 1'b0;
    int pend = 0;
    ops_t o;
    forever begin
      @(negedge clock);
      if (reset) begin half = 1'b0; pend = 0; continue; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (ops_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_issue: got add_a %0d expected none", add_a);
          end else begin
            o = ops_q.pop_front();
            chk("add_a", add_a, o.a);
            chk("add_b", add_b, o.b);
            chk("add_c", add_c, o.c);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (!half && !in_last) half = 1'b1;
        else begin half = 1'b0; pend = 2; end
      end
    end
  end

  initial begin
    int k;
    int len;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    send(1, 0, 0); send(2, 0, 0); send(3, 1, 0);
    drain();

    send(5, 1, 0);
    k = 0;
    do begin @(negedge clock); k++; end while (!sum_valid && k < 20);
    chk("single_word_latency", k, 4);
    drain();

    send(200, 0, 0); send(100, 1, 0);
    for (int i = 0; i < 16; i++) send(255, 0, 0);
    send(255, 1, 0);
    send(1, 1, 0);
    drain();

    sum_ready = 1'b0;
    send(4, 0, 1); send(5, 1, 0);
    k = 0;
    while (!sum_valid && k < 50) begin @(negedge clock); k++; end
    chk("hold_reached_done", sum_valid, 1);
    repeat (5) begin
      @(negedge clock);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clock); #1;
    sum_ready = 1'b1;
    @(posedge clock); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_sum_valid", sum_valid, 0);
    drain();

    send(7, 0, 0); send(8, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk_all_zero("mid_reset");
    reset = 1'b0;
    model_reset();
    send(10, 0, 0); send(20, 1, 0);
    drain();

    for (int i = 1; i <= 7; i++) send(i[W-1:0], i == 7, (i % 2));
    drain();

    rand_ready = 1'b1;
    for (int s = 0; s < 30; s++) begin
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++)
        send(($urandom % 4 == 0) ? 8'd255 : W'($urandom_range(0, 255)),
             j == len - 1, $urandom_range(0, 2));
    end
    drain();
    rand_ready = 1'b0;
    sum_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("ops_queue_empty", ops_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    abort("global_timeout");
  end

endmodule

`default_nettype wire
